cmsdk_mcu_stclkcfg: RTL and testbench
=====================================

# cmsdk_mcu_stclkcfg

Runtime-configurable SysTick reference-enable controller for the Cortex-M0 MCU subsystem. It replaces fixed-ratio SysTick divider generation with a sequenced divider. Reload, enable and calibration updates arrive over a valid/ready config port and are applied only at a half-period boundary, so STCLKEN never shows a shortened phase. It sits between the system control registers and the processor's STCLKEN/STCALIB inputs.

## Interface
- CNT_W, 18: divider counter width.
- RESET_RELOAD, 18'd499: half-period reload after reset (period = 2×(reload+1) FCLK cycles).
- RESET_EN, 1'b1: enable state after reset.
- RESET_CALIB, 24'd0: STCALIB[23:0] after reset.

Ports:
- FCLK  in  1  free-running clock; sole clock.
- SYSRESET  in  1  reset; synchronous and active-high.
- CFG_VALID  in  1  config request.
- CFG_READY  out  1  config port can accept.
- CFG_ENABLE  in  1  requested enable.
- CFG_RELOAD  in  CNT_W  requested half-period reload.
- CFG_SKEW  in  1  requested STCALIB[24].
- CFG_CALIB  in  24  requested STCALIB[23:0].
- STCLKEN  out  1  SysTick reference clock, registered.
- STCALIB  out  26  {NOREF, SKEW, TENMS}.
- BUSY  out  1  update or drain in progress.

## Operation
- Active registers hold reload_a, skew_a, calib_a and en_a. Shadow registers hold a captured request.
- States:
  - DISABLED: counter held at 0, STCLKEN=0.
  - RUN: normal division.
  - PENDING: update captured, waiting for a boundary.
  - DRAIN: disable requested, waiting for STCLKEN to fall.
- Counter behaviour in RUN, PENDING and DRAIN:
  - cnt==0 is a boundary. On a boundary, STCLKEN toggles and cnt loads reload_a, or the shadow reload if applying.
  - Otherwise cnt decrements by 1.
- CFG_READY=1 only in DISABLED and RUN. A transfer is VALID&READY. Requests with READY=0 are not captured; the requester holds VALID.
- Transfer in DISABLED with CFG_ENABLE=1: active regs load next cycle, cnt loads CFG_RELOAD, state RUN, STCLKEN stays 0.
- Transfer in DISABLED with CFG_ENABLE=0: active regs update, stay DISABLED.
- Transfer in RUN with CFG_ENABLE=1: capture shadow, go to PENDING. At the next boundary, toggle, load the shadow reload into cnt, copy shadow to active, return to RUN.
- Transfer in RUN with CFG_ENABLE=0: capture shadow, go to DRAIN.
  - At a boundary where STCLKEN==1: toggle to 0, cnt<=0, copy shadow, go to DISABLED.
  - At a boundary where STCLKEN==0: toggle to 1 and continue.
- STCALIB[25] (NOREF) = ~en_a. STCALIB[24] = skew_a. STCALIB[23:0] = calib_a. All change only with the active copy.
- BUSY = state is PENDING or DRAIN.
- Reload 0 is legal: STCLKEN toggles every cycle, period 2.

## Timing
- Reset values, SYSRESET high on a FCLK edge:
  - STCLKEN=0, cnt=0, reload_a=RESET_RELOAD, en_a=RESET_EN, skew_a=1, calib_a=RESET_CALIB, BUSY=0.
  - State is RUN if RESET_EN, else DISABLED.
- With RESET_EN=1: STCLKEN rises at the first edge after reset release (cnt=0 boundary), then toggles every RESET_RELOAD+1 cycles.
- All outputs are registered. CFG_READY is combinational from state only.
- PENDING/DRAIN latency: cnt+1 cycles from capture to the boundary. DRAIN can take up to 2×(reload_a+1).
- SYSRESET asserted mid-PENDING or mid-DRAIN discards the shadow and restores the reset values on that edge.
- Counter arithmetic is CNT_W-bit unsigned. The decrement happens only when cnt≠0, so it never wraps.

## Structure
- Package cmsdk_mcu_stclkcfg_pkg holds:
  - the state enum (DISABLED, RUN, PENDING, DRAIN);
  - the STCALIB bit-index constants (NOREF=25, SKEW=24, TENMS msb=23);
  - the config record typedef {enable, reload, skew, calib}.
- One sub-module, cmsdk_mcu_stclkcfg_div, holds the loadable down-counter with boundary flag and toggle register. The top holds the FSM, shadow/active registers and handshake.

## Test plan
- Reset with RESET_EN=1, RESET_RELOAD=499, release -> STCLKEN high at cycle 1, period 1000 cycles, STCALIB=26'h1000000.
- In RUN with reload 499, at cnt=200, write reload 9, calib 24'd1234 -> READY low 201 cycles, BUSY high, that phase lasts 500 cycles, subsequent phases last 10, STCALIB[23:0]=1234 from the same edge.
- Disable while STCLKEN=0 -> one full high phase completes, STCLKEN ends 0, STCALIB[25]=1, state DISABLED, cnt=0.
- From DISABLED write enable, reload 0 -> STCLKEN toggles every cycle starting 1 cycle after load (period 2).
- CFG_VALID held during PENDING with different data -> the second request is accepted only after READY returns, and the first is applied unaltered.
- Assert SYSRESET during DRAIN -> next edge STCLKEN=0, BUSY=0, reload_a=RESET_RELOAD, shadow discarded.

Source files
------------

// File: rtl/cmsdk_mcu_stclkcfg_pkg.sv
// rtl/cmsdk_mcu_stclkcfg_pkg.sv - shared types and constants for the SysTick reference-enable controller
package cmsdk_mcu_stclkcfg_pkg;

    localparam int STCLK_CNT_W = 18;

    localparam int STCALIB_NOREF     = 25;
    localparam int STCALIB_SKEW      = 24;
    localparam int STCALIB_TENMS_MSB = 23;

    typedef enum logic [1:0] {
        DISABLED = 2'd0,
        RUN      = 2'd1,
        PENDING  = 2'd2,
        DRAIN    = 2'd3
    } stclk_state_t;

    typedef struct packed {
        logic                   enable;
        logic [STCLK_CNT_W-1:0] reload;
        logic                   skew;
        logic [23:0]            calib;
    } stclk_cfg_t;

endpackage

// File: rtl/cmsdk_mcu_stclkcfg_div.sv
// rtl/cmsdk_mcu_stclkcfg_div.sv - loadable half-period down-counter with boundary flag and toggle register
module cmsdk_mcu_stclkcfg_div #(
    parameter int CNT_W = 18
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             active,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic [CNT_W-1:0] bnd_val,
    input  logic             stop,
    output logic             boundary,
    output logic             clk_en
);

    logic [CNT_W-1:0] cnt_q;
    logic             tog_q;

    // boundary only counts while dividing; a parked counter also sits at zero
    assign boundary = active && (cnt_q == '0);
    assign clk_en   = tog_q;

    // counter and toggle: direct load, park at zero, toggle+reload on boundary, else count down
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
            tog_q <= 1'b0;
        end else if (load) begin
            cnt_q <= load_val;
        end else if (!active) begin
            cnt_q <= '0;
            tog_q <= 1'b0;
        end else if (cnt_q == '0) begin
            tog_q <= ~tog_q;
            cnt_q <= stop ? '0 : bnd_val;
        end else begin
            cnt_q <= cnt_q - 1'b1;
        end
    end

endmodule

// File: rtl/cmsdk_mcu_stclkcfg.sv
// rtl/cmsdk_mcu_stclkcfg.sv - SysTick reference-enable controller with boundary-aligned config updates
module cmsdk_mcu_stclkcfg
    import cmsdk_mcu_stclkcfg_pkg::*;
#(
    parameter int               CNT_W        = STCLK_CNT_W,
    parameter logic [CNT_W-1:0] RESET_RELOAD = 18'd499,
    parameter logic             RESET_EN     = 1'b1,
    parameter logic [23:0]      RESET_CALIB  = 24'd0
) (
    input  logic             FCLK,
    input  logic             SYSRESET,
    input  logic             CFG_VALID,
    output logic             CFG_READY,
    input  logic             CFG_ENABLE,
    input  logic [CNT_W-1:0] CFG_RELOAD,
    input  logic             CFG_SKEW,
    input  logic [23:0]      CFG_CALIB,
    output logic             STCLKEN,
    output logic [25:0]      STCALIB,
    output logic             BUSY
);

    stclk_state_t     state_q, state_d;
    stclk_cfg_t       act_q, sh_q, cfg_in;
    logic             xfer;
    logic             capture, load_act_cfg, apply_sh, div_load, stop;
    logic             boundary, clk_en;
    logic [CNT_W-1:0] bnd_val;

    assign cfg_in    = '{enable: CFG_ENABLE, reload: CFG_RELOAD, skew: CFG_SKEW, calib: CFG_CALIB};
    assign CFG_READY = (state_q == DISABLED) || (state_q == RUN);
    assign xfer      = CFG_VALID && CFG_READY;
    assign BUSY      = (state_q == PENDING) || (state_q == DRAIN);
    assign STCLKEN   = clk_en;

    assign STCALIB[STCALIB_NOREF]         = ~act_q.enable;
    assign STCALIB[STCALIB_SKEW]          = act_q.skew;
    assign STCALIB[STCALIB_TENMS_MSB:0]   = act_q.calib;

    // state register
    always_ff @(posedge FCLK) begin
        if (SYSRESET) begin
            state_q <= RESET_EN ? RUN : DISABLED;
        end else begin
            state_q <= state_d;
        end
    end

    // next-state and per-cycle control strobes
    always_comb begin
        state_d      = state_q;
        capture      = 1'b0;
        load_act_cfg = 1'b0;
        apply_sh     = 1'b0;
        div_load     = 1'b0;
        stop         = 1'b0;
        bnd_val      = act_q.reload;
        case (state_q)
            DISABLED: begin
                if (xfer) begin
                    load_act_cfg = 1'b1;
                    if (CFG_ENABLE) begin
                        div_load = 1'b1;
                        state_d  = RUN;
                    end
                end
            end
            RUN: begin
                if (xfer) begin
                    capture = 1'b1;
                    state_d = CFG_ENABLE ? PENDING : DRAIN;
                end
            end
            PENDING: begin
                bnd_val = sh_q.reload;
                if (boundary) begin
                    apply_sh = 1'b1;
                    state_d  = RUN;
                end
            end
            DRAIN: begin
                // only stop on the falling boundary so the high phase is never cut short
                if (boundary && clk_en) begin
                    stop     = 1'b1;
                    apply_sh = 1'b1;
                    state_d  = DISABLED;
                end
            end
            default: state_d = DISABLED;
        endcase
    end

    // active configuration: direct load while disabled, shadow copy at a boundary
    always_ff @(posedge FCLK) begin
        if (SYSRESET) begin
            act_q <= '{enable: RESET_EN, reload: RESET_RELOAD, skew: 1'b1, calib: RESET_CALIB};
        end else if (load_act_cfg) begin
            act_q <= cfg_in;
        end else if (apply_sh) begin
            act_q <= sh_q;
        end
    end

    // shadow configuration captured while running; cleared on reset so nothing stale survives
    always_ff @(posedge FCLK) begin
        if (SYSRESET) begin
            sh_q <= '0;
        end else if (capture) begin
            sh_q <= cfg_in;
        end
    end

    cmsdk_mcu_stclkcfg_div #(.CNT_W(CNT_W)) u_div (
        .clk      (FCLK),
        .rst      (SYSRESET),
        .active   (state_q != DISABLED),
        .load     (div_load),
        .load_val (CFG_RELOAD),
        .bnd_val  (bnd_val),
        .stop     (stop),
        .boundary (boundary),
        .clk_en   (clk_en)
    );

endmodule

// File: tb/tb_cmsdk_mcu_stclkcfg.sv
// tb/tb_cmsdk_mcu_stclkcfg.sv - directed self-checking bench for cmsdk_mcu_stclkcfg
module tb_cmsdk_mcu_stclkcfg;

    logic        FCLK       = 1'b0;
    logic        SYSRESET   = 1'b1;
    logic        CFG_VALID  = 1'b0;
    logic        CFG_ENABLE = 1'b0;
    logic [17:0] CFG_RELOAD = '0;
    logic        CFG_SKEW   = 1'b0;
    logic [23:0] CFG_CALIB  = '0;
    logic        CFG_READY;
    logic        STCLKEN;
    logic [25:0] STCALIB;
    logic        BUSY;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;
    int n;
    int rec;

    cmsdk_mcu_stclkcfg dut (
        .FCLK       (FCLK),
        .SYSRESET   (SYSRESET),
        .CFG_VALID  (CFG_VALID),
        .CFG_READY  (CFG_READY),
        .CFG_ENABLE (CFG_ENABLE),
        .CFG_RELOAD (CFG_RELOAD),
        .CFG_SKEW   (CFG_SKEW),
        .CFG_CALIB  (CFG_CALIB),
        .STCLKEN    (STCLKEN),
        .STCALIB    (STCALIB),
        .BUSY       (BUSY)
    );

    always #5 FCLK = ~FCLK;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expd);
        n_checks++;
        if (obs === expd) n_pass++;
        else $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, obs, obs, expd, expd);
    endtask

    task automatic tick();
        @(posedge FCLK);
        #1;
        cyc++;
    endtask

    task automatic wait_change(output int cnt);
        logic start;
        start = STCLKEN;
        cnt = 0;
        do begin
            tick();
            cnt++;
        end while (STCLKEN == start && cnt < 5000);
    endtask

    task automatic wait_ready(output int cnt);
        cnt = 0;
        do begin
            tick();
            cnt++;
        end while (!CFG_READY && cnt < 5000);
    endtask

    task automatic send(input logic en, input logic [17:0] rl, input logic sk, input logic [23:0] cal);
        CFG_ENABLE = en;
        CFG_RELOAD = rl;
        CFG_SKEW   = sk;
        CFG_CALIB  = cal;
        CFG_VALID  = 1'b1;
    endtask

    initial begin
        // reset values
        repeat (3) tick();
        check("rst_stclken", STCLKEN, 0);
        check("rst_busy", BUSY, 0);
        check("rst_ready", CFG_READY, 1);
        check("rst_stcalib", STCALIB, 26'h1000000);

        // free-running division with reset reload 499
        SYSRESET = 1'b0;
        tick();
        check("first_rise", STCLKEN, 1);
        wait_change(n);
        check("high_phase", n, 500);
        wait_change(n);
        check("low_phase", n, 500);
        check("cnt_after_toggle", dut.u_div.cnt_q, 499);
        rec = cyc;

        // update captured at cnt=200 waits for the boundary
        repeat (298) tick();
        check("cnt_pre_capture", dut.u_div.cnt_q, 201);
        send(1'b1, 18'd9, 1'b1, 24'd1234);
        tick();
        CFG_VALID = 1'b0;
        check("pend_ready", CFG_READY, 0);
        check("pend_busy", BUSY, 1);
        check("pend_cnt", dut.u_div.cnt_q, 200);
        repeat (200) tick();
        check("pend_hold_stclken", STCLKEN, 1);
        check("pend_hold_calib", STCALIB[23:0], 0);
        check("pend_hold_ready", CFG_READY, 0);
        tick();
        check("pend_apply_stclken", STCLKEN, 0);
        check("pend_apply_ready", CFG_READY, 1);
        check("pend_apply_busy", BUSY, 0);
        check("pend_apply_calib", STCALIB[23:0], 1234);
        check("pend_full_phase", cyc - rec, 500);
        wait_change(n);
        check("reload9_phase_a", n, 10);
        wait_change(n);
        check("reload9_phase_b", n, 10);

        // VALID held through PENDING with new data
        send(1'b1, 18'd4, 1'b1, 24'd55);
        tick();
        CFG_RELOAD = 18'd6;
        CFG_CALIB  = 24'd77;
        check("held_busy", BUSY, 1);
        wait_ready(n);
        check("held_a_latency", n, 9);
        rec = cyc;
        check("held_a_calib", STCALIB[23:0], 55);
        check("held_a_reload", dut.act_q.reload, 4);
        tick();
        CFG_VALID = 1'b0;
        check("held_b_captured", BUSY, 1);
        wait_ready(n);
        check("held_b_latency", n, 4);
        check("held_a_phase", cyc - rec, 5);
        check("held_b_calib", STCALIB[23:0], 77);
        wait_change(n);
        check("held_b_phase", n, 7);

        // disable requested at the start of a low phase
        if (STCLKEN) begin
            wait_change(n);
        end else begin
            wait_change(n);
            wait_change(n);
        end
        check("drain_start_cnt", dut.u_div.cnt_q, 6);
        send(1'b0, 18'd3, 1'b0, 24'd99);
        tick();
        CFG_VALID = 1'b0;
        check("drain_busy", BUSY, 1);
        wait_ready(n);
        check("drain_latency", n, 13);
        check("drain_stclken", STCLKEN, 0);
        check("drain_stcalib", STCALIB, 26'h2000063);
        check("drain_cnt", dut.u_div.cnt_q, 0);
        repeat (3) tick();
        check("disabled_hold", STCLKEN, 0);
        check("disabled_ready", CFG_READY, 1);

        // enable from DISABLED with reload 0
        send(1'b1, 18'd0, 1'b1, 24'd5);
        tick();
        CFG_VALID = 1'b0;
        check("en_load_stclken", STCLKEN, 0);
        check("en_load_stcalib", STCALIB, 26'h1000005);
        for (int i = 0; i < 4; i++) begin
            tick();
            check("reload0_toggle", STCLKEN, (i % 2 == 0) ? 1 : 0);
        end

        // reset asserted mid-DRAIN
        send(1'b1, 18'd20, 1'b1, 24'd5);
        tick();
        CFG_VALID = 1'b0;
        check("r20_busy", BUSY, 1);
        wait_ready(n);
        check("r20_latency", n, 1);
        check("r20_cnt", dut.u_div.cnt_q, 20);
        send(1'b0, 18'd7, 1'b0, 24'd0);
        tick();
        CFG_VALID = 1'b0;
        repeat (3) tick();
        check("mid_drain_busy", BUSY, 1);
        SYSRESET = 1'b1;
        tick();
        check("rst_drain_stclken", STCLKEN, 0);
        check("rst_drain_busy", BUSY, 0);
        check("rst_drain_reload", dut.act_q.reload, 499);
        check("rst_drain_stcalib", STCALIB, 26'h1000000);
        check("rst_drain_ready", CFG_READY, 1);
        SYSRESET = 1'b0;
        tick();
        check("rst_drain_rise", STCLKEN, 1);
        wait_change(n);
        check("rst_drain_phase", n, 500);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
